// File: rtl/mips_data_mem.sv
// Word-addressed data memory responder for the mips_32 load/store port.
// One request at a time, WAIT_CYCLES wait states, byte-enabled stores, misalignment flag.
module mips_data_mem #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        addr_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Handshake: the requester raises req with we/addr/wdata/be and holds them
    // stable until it sees the one-cycle ready strobe. A request is taken on
    // any rising edge where the FSM is in IDLE and req is high; req is ignored
    // in WAIT and RESP, so a requester that keeps req high through ready
    // starts its next transaction on the following IDLE edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH+1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  ready_q, ready_d;
    logic                  addr_err_q, addr_err_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [31:0]           mem [DEPTH];

    logic                  enter_resp;
    logic                  acc_we;
    logic [ADDR_WIDTH+1:0] acc_addr;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_be;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  acc_aligned;
    logic                  mem_wr;

    // Upper address bits alias into the array and are deliberately dropped.
    logic addr_hi_unused;
    assign addr_hi_unused = ^addr[31:ADDR_WIDTH+2];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr[ADDR_WIDTH+1:0];
                    wdata_d = wdata;
                    be_d    = be;
                    cnt_d   = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d      = 4'd0;
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // With zero wait states the array is accessed on the capture edge itself,
    // so the fields come straight from the ports rather than the holding regs.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we    = we;
            acc_addr  = addr[ADDR_WIDTH+1:0];
            acc_wdata = wdata;
            acc_be    = be;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
        acc_idx     = acc_addr[ADDR_WIDTH+1:2];
        acc_aligned = (acc_addr[1:0] == 2'b00);
        mem_wr      = enter_resp && acc_we && acc_aligned;
    end

    always_comb begin
        rdata_d    = rdata_q;
        ready_d    = (state_q == S_RESP);
        addr_err_d = (state_q == S_RESP) && (addr_q[1:0] != 2'b00);
        if (enter_resp && !acc_we && acc_aligned) begin
            rdata_d = mem[acc_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            ready_q    <= 1'b0;
            addr_err_q <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            ready_q    <= ready_d;
            addr_err_q <= addr_err_d;
            rdata_q    <= rdata_d;
        end
    end

    // The array has no reset; contents survive a mid-transaction reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_wr && acc_be[i]) begin
                mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    assign ready    = ready_q;
    assign rdata    = rdata_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mips_data_mem.sv
// Directed bench for mips_data_mem: default instance (2 wait states) and a
// zero-wait-state instance used for the streaming case.
module tb_mips_data_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ready;
    logic [31:0] rdata;
    logic        addr_err;

    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  be0;
    logic        ready0;
    logic [31:0] rdata0;
    logic        addr_err0;

    int checks = 0;
    int errors = 0;

    mips_data_mem #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .ready(ready), .rdata(rdata), .addr_err(addr_err)
    );

    mips_data_mem #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0),
        .wdata(wdata0), .be(be0), .ready(ready0), .rdata(rdata0), .addr_err(addr_err0)
    );

    // One transaction on the default instance. lat counts edges after the
    // capture edge until ready is seen (-1 on timeout); rdy_after is ready one
    // cycle after the strobe.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output int lat, output logic [31:0] rd,
                        output logic ae, output logic rdy_after);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = c;
                break;
            end
        end
        rd = rdata; ae = addr_err;
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
        @(posedge clk); #1;
        rdy_after = ready;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 0; we = 0; addr = 0; wdata = 0; be = 0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; be0 = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
        checks++;
        if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        checks++;
        if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got %b exp 0", addr_err); end
        checks++;
        if (ready0 !== 1'b0 || rdata0 !== 32'd0) begin
            errors++; $display("FAIL reset_dut0 got ready %b rdata %h exp 0/0", ready0, rdata0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic ae, ra;
        xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, lat, rd, ae, ra);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL store_latency got %0d exp 3", lat); end
        checks++;
        if (ae !== 1'b0) begin errors++; $display("FAIL store_addr_err got %b exp 0", ae); end
        checks++;
        if (ra !== 1'b0) begin errors++; $display("FAIL store_ready_pulse got %b exp 0", ra); end
        xact(1'b0, 32'h0000_0010, 32'd0, 4'b0000, lat, rd, ae, ra);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d exp 3", lat); end
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata got %h exp deadbeef", rd); end
        checks++;
        if (ae !== 1'b0) begin errors++; $display("FAIL load_addr_err got %b exp 0", ae); end
        checks++;
        if (ra !== 1'b0) begin errors++; $display("FAIL load_ready_pulse got %b exp 0", ra); end
    endtask

    task automatic test_byte_enable();
        int lat; logic [31:0] rd; logic ae, ra;
        xact(1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101, lat, rd, ae, ra);
        xact(1'b0, 32'h0000_0010, 32'd0, 4'b0000, lat, rd, ae, ra);
        checks++;
        if (rd !== 32'hDE22_BE44) begin errors++; $display("FAIL be_merge got %h exp de22be44", rd); end
        xact(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, lat, rd, ae, ra);
        checks++;
        if (lat !== 3 || ae !== 1'b0) begin
            errors++; $display("FAIL be_zero_complete got lat %0d err %b exp 3/0", lat, ae);
        end
        xact(1'b0, 32'h0000_0010, 32'd0, 4'b0000, lat, rd, ae, ra);
        checks++;
        if (rd !== 32'hDE22_BE44) begin errors++; $display("FAIL be_zero_nochange got %h exp de22be44", rd); end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic ae, ra;
        xact(1'b1, 32'h0000_0012, 32'h0000_0000, 4'b1111, lat, rd, ae, ra);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL mis_store_latency got %0d exp 3", lat); end
        checks++;
        if (ae !== 1'b1) begin errors++; $display("FAIL mis_store_addr_err got %b exp 1", ae); end
        checks++;
        if (addr_err !== 1'b0) begin errors++; $display("FAIL mis_err_pulse got %b exp 0", addr_err); end
        xact(1'b0, 32'h0000_0010, 32'd0, 4'b0000, lat, rd, ae, ra);
        checks++;
        if (rd !== 32'hDE22_BE44) begin errors++; $display("FAIL mis_store_nowrite got %h exp de22be44", rd); end
        xact(1'b0, 32'h0000_0013, 32'd0, 4'b0000, lat, rd, ae, ra);
        checks++;
        if (ae !== 1'b1) begin errors++; $display("FAIL mis_load_addr_err got %b exp 1", ae); end
        checks++;
        if (rd !== 32'hDE22_BE44) begin errors++; $display("FAIL mis_load_rdata_hold got %h exp de22be44", rd); end
    endtask

    task automatic test_alias();
        int lat; logic [31:0] rd; logic ae, ra;
        xact(1'b1, 32'h0000_1004, 32'hA5A5_A5A5, 4'b1111, lat, rd, ae, ra);
        xact(1'b0, 32'h0000_0004, 32'd0, 4'b0000, lat, rd, ae, ra);
        checks++;
        if (rd !== 32'hA5A5_A5A5) begin errors++; $display("FAIL alias_rdata got %h exp a5a5a5a5", rd); end
    endtask

    task automatic test_back_to_back();
        int lat; int gap;
        req = 1'b1; we = 1'b1; addr = 32'h0000_0030; wdata = 32'h0102_0304; be = 4'b1111;
        @(posedge clk); #1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ready) begin lat = c; break; end
        end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL b2b_first_latency got %0d exp 3", lat); end
        we = 1'b0; wdata = 32'd0;
        gap = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ready) begin gap = c; break; end
        end
        checks++;
        if (gap !== 4) begin errors++; $display("FAIL b2b_gap got %0d exp 4", gap); end
        checks++;
        if (rdata !== 32'h0102_0304) begin errors++; $display("FAIL b2b_rdata got %h exp 01020304", rdata); end
        req = 1'b0; addr = 32'd0; be = 4'd0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_store();
        int lat; int seen; logic [31:0] rd; logic ae, ra;
        xact(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'b1111, lat, rd, ae, ra);
        req = 1'b1; we = 1'b1; addr = 32'h0000_0020; wdata = 32'h1234_5678; be = 4'b1111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
        #1;
        checks++;
        if (ready !== 1'b0 || addr_err !== 1'b0 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got ready %b err %b rdata %h exp 0/0/0", ready, addr_err, rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL mid_reset_no_ready got %0d pulses exp 0", seen); end
        xact(1'b0, 32'h0000_0020, 32'd0, 4'b0000, lat, rd, ae, ra);
        checks++;
        if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL mid_reset_discard got %h exp 0badf00d", rd); end
    endtask

    task automatic test_stream_zero_wait();
        logic exp_rdy;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0000_0008; wdata0 = 32'hCAFE_F00D; be0 = 4'b1111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (ready0 !== 1'b1) begin errors++; $display("FAIL zw_store_latency got ready %b exp 1", ready0); end
        req0 = 1'b0; we0 = 1'b0; wdata0 = 32'd0; be0 = 4'd0;
        @(posedge clk); #1;
        req0 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            exp_rdy = (k % 2 == 0) && (k <= 8);
            checks++;
            if (ready0 !== exp_rdy) begin
                errors++; $display("FAIL zw_stream_ready k=%0d got %b exp %b", k, ready0, exp_rdy);
            end
            if (exp_rdy) begin
                checks++;
                if (rdata0 !== 32'hCAFE_F00D || addr_err0 !== 1'b0) begin
                    errors++;
                    $display("FAIL zw_stream_data k=%0d got %h err %b exp cafef00d/0", k, rdata0, addr_err0);
                end
            end
            if (k == 8) req0 = 1'b0;
        end
        addr0 = 32'd0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_byte_enable();
        test_misaligned();
        test_alias();
        test_back_to_back();
        test_reset_mid_store();
        test_stream_zero_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_data_mem.md
# mips_data_mem

Word-addressed data-memory responder for the `mips_32` core's load/store port: the core initiates, this block responds. It sits beside the core in the top-level and in simulation benches. It accepts one request at a time over a req/ready handshake and inserts a programmable number of wait states before responding. Byte-enabled writes and misaligned-address detection are included, so the core's stall logic is exercised rather than bypassed.

## Interface
- `ADDR_WIDTH`, default 10, is the word-address width. Depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, default 2, is the number of wait states between request capture and response. Legal range is 0–15.
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  request valid. The requester holds it and all request fields stable until `ready`.
- `we`  in  1  1 = store, 0 = load.
- `addr`  in  32  byte address from the core's ALU result.
- `wdata`  in  32  store data.
- `be`  in  4  store byte enables; `be[i]` covers `wdata[8i+7:8i]`. Ignored on loads.
- `ready`  out  1  one-cycle response strobe.
- `rdata`  out  32  load data. Valid while `ready` is high after a load; otherwise holds the last load value.
- `addr_err`  out  1  asserted together with `ready` when the request was misaligned.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - When `req`=1 at a rising edge, capture `we`, `addr`, `wdata`, `be` into holding registers.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT, or go directly to RESP if `WAIT_CYCLES`=0.
- **WAIT**
  - Decrement the counter each cycle.
  - Go to RESP on the edge where the counter reaches 0.
- **RESP**
  - `ready`=1 for exactly one cycle, then return to IDLE unconditionally.
  - `req` is not sampled in RESP, even if it is high.
- **Memory update on the edge that enters RESP**
  - Store: write each byte lane whose `be` bit is set. `be`=0000 still completes normally with no change to memory.
  - Load: `rdata` is loaded with the word at the captured address.
- **Indexing:** word index = `addr[ADDR_WIDTH+1:2]`. Address bits above this field are ignored, so upper addresses alias into the array.
- **Misaligned requests:** if `addr[1:0]` ≠ 00, the request still runs the full WAIT sequence. In RESP, `addr_err`=1. Memory is not written and `rdata` is not updated.
- Request fields are sampled only at capture. Changes to them during WAIT have no effect.

## Timing
- **Reset values:** state IDLE, counter 0, `ready`=0, `rdata`=0, `addr_err`=0, holding registers 0.
- **Reset and memory contents:** the memory array is not cleared by reset.
- **Latency:** with `req` sampled at edge N, `ready` is high during the cycle after edge N+WAIT_CYCLES+1. That is 3 cycles for the default and 1 cycle for `WAIT_CYCLES`=0.
- **Throughput:** at most one transaction per WAIT_CYCLES+2 cycles.
- **Back-to-back requests:** if the requester keeps `req` high after `ready`, the next request is captured on the first edge in IDLE, which is the edge after RESP.
- **Reset mid-transaction:** reset during WAIT or RESP returns the FSM to IDLE immediately and drops `ready` and `addr_err`.
  - A store whose RESP-entry edge has not yet occurred is discarded.
  - A store that already committed remains in memory.
- **Output registration:** `addr_err` and `ready` are registered outputs and change only on clock edges or on reset.

## Test plan
- **Aligned store then load.** Store `addr`=0x0000_0010, `wdata`=0xDEAD_BEEF, `be`=1111, then load the same address.
  - `ready` is seen exactly 3 cycles after each capture.
  - The load returns `rdata`=0xDEAD_BEEF with `addr_err`=0.
- **Byte-enable merge.** Preload word 0x10 with 0xDEAD_BEEF, store 0x1122_3344 with `be`=0101, then load.
  - The load returns 0xDE22_BE44.
- **Misaligned access.**
  - Store to 0x0000_0012 → `ready` and `addr_err` both 1, memory unchanged.
  - Load from 0x0000_0013 → `addr_err`=1, `rdata` keeps its previous value.
- **Zero wait states and streaming.** Instantiate with `WAIT_CYCLES`=0 and hold `req` high for four loads.
  - `ready` pulses every 2 cycles.
  - Each pulse lasts exactly one cycle.
- **Aliasing.** With `ADDR_WIDTH`=10, store 0xA5A5_A5A5 to 0x0000_1004, then load 0x0000_0004.
  - The load returns 0xA5A5_A5A5.
- **Reset mid-store.** Assert `reset` for 1 cycle during WAIT of a store of 0x1234_5678 to 0x20.
  - `ready` stays 0 and all outputs return to their reset values.
  - A following load of 0x20 returns the pre-store contents.
